// File: rtl/zacore_pipeline_control.sv
// zacore_pipeline_control: hazard and flow controller for the five-stage Zacore pipeline.
// Revision 1.0 - initial release.
`default_nettype none

module zacore_pipeline_control #(
  parameter int FETCH_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_decode_valid,
  input  logic [4:0]  i_decode_rs1,
  input  logic [4:0]  i_decode_rs2,
  input  logic        i_decode_uses_rs1,
  input  logic        i_decode_uses_rs2,
  input  logic        i_execute_valid,
  input  logic        i_execute_is_load,
  input  logic [4:0]  i_execute_rd,
  input  logic        i_execute_multicycle,
  input  logic        i_execute_done,
  input  logic        i_execute_redirect,
  input  logic        i_memory_busy,
  output logic        o_fetch_stall,
  output logic        o_decode_stall,
  output logic        o_execute_stall,
  output logic        o_memory_stall,
  output logic        o_fetch_invalidate,
  output logic        o_decode_invalidate,
  output logic        o_execute_invalidate,
  output logic        o_flush_active,
  output logic [31:0] o_stall_cycles
);

  localparam int CW = $clog2(FETCH_LATENCY + 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FETCH_LATENCY - 1);
  localparam logic [CW-1:0] FLUSH_LAST   = CW'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   flush_cnt, flush_cnt_nx;
  logic [31:0]     stall_cnt;

  logic mc_busy;
  logic redirect;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mc_busy  = i_execute_valid & i_execute_multicycle & ~i_execute_done;
  assign redirect = i_execute_valid & i_execute_redirect & ~mc_busy & ~i_memory_busy;
  assign rs1_hit  = i_decode_uses_rs1 & (i_decode_rs1 == i_execute_rd);
  assign rs2_hit  = i_decode_uses_rs2 & (i_decode_rs2 == i_execute_rd);
  assign load_use = i_decode_valid & i_execute_valid & i_execute_is_load &
                    (i_execute_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_nx             = state;
    flush_cnt_nx         = flush_cnt;
    o_fetch_stall        = 1'b0;
    o_decode_stall       = 1'b0;
    o_execute_stall      = 1'b0;
    o_memory_stall       = 1'b0;
    o_fetch_invalidate   = 1'b0;
    o_decode_invalidate  = 1'b0;
    o_execute_invalidate = 1'b0;

    if (i_rst) begin
      o_fetch_invalidate   = 1'b1;
      o_decode_invalidate  = 1'b1;
      o_execute_invalidate = 1'b1;
    end else if (i_memory_busy) begin
      // Whole pipe frozen; state and flush count hold so no flush cycle is lost.
      o_fetch_stall   = 1'b1;
      o_decode_stall  = 1'b1;
      o_execute_stall = 1'b1;
      o_memory_stall  = 1'b1;
    end else if (redirect) begin
      o_fetch_invalidate  = 1'b1;
      o_decode_invalidate = 1'b1;
      if (FETCH_LATENCY > 1) begin
        state_nx     = FLUSH;
        flush_cnt_nx = FLUSH_RELOAD;
      end else begin
        state_nx     = RUN;
        flush_cnt_nx = '0;
      end
    end else begin
      if (mc_busy) begin
        o_fetch_stall        = 1'b1;
        o_decode_stall       = 1'b1;
        o_execute_invalidate = 1'b1;
      end else if (load_use) begin
        o_fetch_stall       = 1'b1;
        o_decode_stall      = 1'b1;
        o_decode_invalidate = 1'b1;
      end

      // A flush in progress keeps running underneath multi-cycle and load-use holds.
      if (state == FLUSH) begin
        o_fetch_invalidate = 1'b1;
        flush_cnt_nx       = flush_cnt - FLUSH_LAST;
        if (flush_cnt == FLUSH_LAST) begin
          state_nx = mc_busy ? MC_WAIT : RUN;
        end
      end else begin
        state_nx = mc_busy ? MC_WAIT : RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      stall_cnt <= 32'd0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      if (o_decode_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign o_flush_active = (state == FLUSH) & ~i_rst;
  assign o_stall_cycles = stall_cnt;

endmodule

`default_nettype wire

// File: doc/zacore_pipeline_control.md
# zacore_pipeline_control

Central hazard and flow controller for the Zacore fetch/decode/execute/memory/writeback pipeline. Observes hazard indications from decode, execute and memory each cycle and drives every stage's stall and invalidate inputs: back-pressure on memory bus waits, bubble insertion for load-use hazards, holding for multi-cycle execute operations, and multi-cycle flushing after a taken branch or jump redirect. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- FETCH_LATENCY, default 2: cycles (>=1) from redirect to the first fetch output from the new PC. Fetch output is invalidated for exactly this many cycles, including the redirect cycle.

Ports:
- i_clk  input  1  pipeline clock; the block uses one clock.
- i_rst  input  1  reset; synchronous and active-high.
- i_decode_valid  input  1  decode holds a valid instruction.
- i_decode_rs1, i_decode_rs2  input  5  source register indices in decode.
- i_decode_uses_rs1, i_decode_uses_rs2  input  1  source actually read.
- i_execute_valid  input  1  execute holds a valid instruction.
- i_execute_is_load  input  1  instruction in execute is a load.
- i_execute_rd  input  5  destination register in execute.
- i_execute_multicycle  input  1  execute op needs more than one cycle.
- i_execute_done  input  1  multi-cycle op result is available this cycle.
- i_execute_redirect  input  1  execute resolved a taken branch or jump.
- i_memory_busy  input  1  memory stage is waiting on the data bus.
- o_fetch_stall, o_decode_stall, o_execute_stall, o_memory_stall  output  1  hold the stage's output flop.
- o_fetch_invalidate, o_decode_invalidate, o_execute_invalidate  output  1  clear the valid bit of the stage's output flop.
- o_flush_active  output  1  the FSM is in the FLUSH state.
- o_stall_cycles  output  32  count of cycles with o_decode_stall high.

## Operation
- Stall and invalidate outputs are combinational from the registered state and the current inputs. The state, the flush counter and o_stall_cycles are registered.
- States: RUN, MC_WAIT, FLUSH. Reset sets RUN, flush counter 0 and o_stall_cycles 0.
- While i_rst is high, all stalls are 0, all invalidates are 1 and o_flush_active is 0.
- Definitions:
  - mc_busy = i_execute_valid & i_execute_multicycle & ~i_execute_done.
  - redirect = i_execute_valid & i_execute_redirect & ~mc_busy & ~i_memory_busy.
  - load_use = i_decode_valid & i_execute_valid & i_execute_is_load & (i_execute_rd != 0) & ((i_decode_uses_rs1 & i_decode_rs1 == i_execute_rd) | (i_decode_uses_rs2 & i_decode_rs2 == i_execute_rd)).
- Conditions are evaluated in priority order, first match wins:
  1. i_memory_busy: all four stalls are 1 and there are no invalidates. The state and flush counter are frozen.
  2. redirect: o_fetch_invalidate and o_decode_invalidate are 1 and there are no stalls. If FETCH_LATENCY > 1, next state is FLUSH with counter = FETCH_LATENCY-1; otherwise next state is RUN. A redirect while already in FLUSH reloads the counter.
  3. mc_busy: fetch and decode stall, o_execute_stall is 0, o_execute_invalidate is 1 (a bubble to memory each cycle). Next state is MC_WAIT.
  4. load_use: fetch and decode stall, o_decode_invalidate is 1 (a bubble into execute). This is a single cycle and needs no state; it clears once the load advances.
  5. Otherwise there are no stalls and no invalidates.
- FLUSH (overlaid on rules 3-5): o_fetch_invalidate is 1 and the counter decrements each unfrozen cycle. Return to RUN after the cycle in which counter == 1. Load-use detection still applies to the decode contents.
- MC_WAIT returns to RUN in the cycle after i_execute_done (mc_busy low). The done cycle itself uses normal rules, and a redirect is allowed that cycle.
- o_stall_cycles increments by 1 on every non-reset cycle in which o_decode_stall is 1. It wraps modulo 2^32.

## Timing
- Stall and invalidate responses take 0 cycles: same cycle as the causing input.
- Redirect: fetch output is invalid for exactly FETCH_LATENCY consecutive unfrozen cycles; decode output is invalid for 1 cycle.
- Load-use costs exactly 1 bubble cycle. Multi-cycle ops cost N-1 stall cycles for N cycles of execute occupancy.
- A memory wait during FLUSH extends the flush by the number of busy cycles, with no count lost.
- A redirect during a memory wait is deferred until i_memory_busy drops, because execute is held.
- Asserting reset mid-MC_WAIT or mid-FLUSH returns to RUN on the next edge with all counters cleared.

## Test plan
- Reset: hold i_rst for 2 cycles -> all invalidates 1, all stalls 0, o_stall_cycles = 0. After release, with idle inputs, all outputs are 0.
- Load-use: execute load with rd=5; decode uses_rs2=1, rs2=5 -> one cycle of fetch/decode stall plus o_decode_invalidate. With rd=0 -> no stall. o_stall_cycles goes to 1.
- Multi-cycle: execute_multicycle with done on the 4th cycle -> 3 cycles of fetch/decode stall with o_execute_invalidate; cycle 4 is clean; state returns to RUN.
- Redirect, FETCH_LATENCY=2: redirect pulse -> fetch and decode invalidate in cycle 0; fetch invalidate in cycle 1 with o_flush_active=1; cycle 2 is clean.
- Memory busy for 3 cycles during FLUSH -> all stalls for 3 cycles, flush resumes afterwards and fetch is still invalidated for 1 remaining cycle. Simultaneous load_use and i_memory_busy -> memory rule only, no invalidate.
- Counter wrap: force o_stall_cycles to 0xFFFFFFFF, then cause one stall -> it reads 0.
